// File: rtl/l1_line_fetch_master_if.sv
// L1 <-> memory line-transfer bundle.
// master = the fetch engine, slave = L1 plus memory side.
interface l1_line_fetch_master_if;
  logic        REQ_VALID;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic        REQ_READY;
  logic [2:0]  WB_IDX;
  logic [31:0] WB_DATA;
  logic        FILL_VALID;
  logic [2:0]  FILL_IDX;
  logic [31:0] FILL_DATA;
  logic        DONE;
  logic        ERR;
  logic        MEM_VALID;
  logic        MEM_READY;
  logic        MEM_LOAD;
  logic        MEM_STORE;
  logic [31:0] MEM_DATA_OUT;
  logic [31:0] MEM_DATA_IN;
  logic        ACK_ADDR;
  logic [3:0]  ACK_DATA_L1;
  logic [3:0]  ACK_DATA_MEM;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, WB_DATA,
    input  MEM_READY, MEM_DATA_IN, ACK_DATA_MEM,
    output REQ_READY, WB_IDX, FILL_VALID, FILL_IDX, FILL_DATA,
    output DONE, ERR, MEM_VALID, MEM_LOAD, MEM_STORE,
    output MEM_DATA_OUT, ACK_ADDR, ACK_DATA_L1
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, WB_DATA,
    output MEM_READY, MEM_DATA_IN, ACK_DATA_MEM,
    input  REQ_READY, WB_IDX, FILL_VALID, FILL_IDX, FILL_DATA,
    input  DONE, ERR, MEM_VALID, MEM_LOAD, MEM_STORE,
    input  MEM_DATA_OUT, ACK_ADDR, ACK_DATA_L1
  );
endinterface

// File: rtl/l1_line_fetch_master.sv
// Line refill / write-back initiator toward main memory.
// Define TIMEOUT_EN to add a watchdog abort after TIMEOUT_CYCLES.
module l1_line_fetch_master #(
  parameter int WORDS_PER_LINE  = 8,
  parameter int LINE_BYTES_LOG2 = 5
`ifdef TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic CLK,
  input logic RST_N,
  l1_line_fetch_master_if.master bus
);
  localparam logic [2:0]  LAST = 3'(WORDS_PER_LINE - 1);
  localparam logic [31:0] BASE_MASK =
    ~((32'd1 << LINE_BYTES_LOG2) - 32'd1);
  localparam logic [3:0]  NONE   = 4'hF;
  localparam logic [3:0]  ST_ACC = 4'hE;

  typedef enum logic [2:0] {
    IDLE, HANDSHAKE, ADDR, LOAD_DATA, STORE_DATA, FINISH
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic        is_wr;
  logic [2:0]  k;
  logic        ld_hit;
  logic        st_hit;
  logic        addr_acc;
  logic        tmo;
  logic        abort;

  assign bus.REQ_READY = (state == IDLE);
  assign bus.WB_IDX    = k;

  assign ld_hit   = bus.ACK_DATA_MEM == {1'b0, k};
  // only ack a store word once its data is actually on the bus
  assign st_hit   = ld_hit && bus.ACK_DATA_L1 == {1'b0, k};
  assign addr_acc = is_wr ? bus.ACK_DATA_MEM == ST_ACC
                          : bus.ACK_DATA_MEM == 4'h0;

`ifdef TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          kick;

  always_comb begin
    kick = 1'b1;
    unique case (state)
      IDLE:       kick = 1'b1;
      HANDSHAKE:  kick = bus.MEM_READY;
      ADDR:       kick = !bus.MEM_READY || addr_acc;
      LOAD_DATA:  kick = !bus.MEM_READY || ld_hit;
      STORE_DATA: kick = !bus.MEM_READY || st_hit;
      FINISH:     kick = !bus.MEM_READY;
      default:    kick = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    wd <= '0;
    else if (kick) wd <= '0;
    else           wd <= wd + WW'(1);
  end

  assign tmo = !kick && (wd == WW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign abort = tmo || (!bus.MEM_READY &&
    (state inside {ADDR, LOAD_DATA, STORE_DATA}));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      base             <= '0;
      is_wr            <= 1'b0;
      k                <= '0;
      bus.MEM_VALID    <= 1'b0;
      bus.MEM_LOAD     <= 1'b0;
      bus.MEM_STORE    <= 1'b0;
      bus.MEM_DATA_OUT <= '0;
      bus.ACK_ADDR     <= 1'b0;
      bus.ACK_DATA_L1  <= NONE;
      bus.FILL_VALID   <= 1'b0;
      bus.FILL_IDX     <= '0;
      bus.FILL_DATA    <= '0;
      bus.DONE         <= 1'b0;
      bus.ERR          <= 1'b0;
    end else begin
      bus.FILL_VALID <= 1'b0;
      bus.DONE       <= 1'b0;
      bus.ERR        <= 1'b0;
      if (abort) begin
        state           <= IDLE;
        k               <= '0;
        bus.MEM_VALID   <= 1'b0;
        bus.MEM_LOAD    <= 1'b0;
        bus.MEM_STORE   <= 1'b0;
        bus.ACK_ADDR    <= 1'b0;
        bus.ACK_DATA_L1 <= NONE;
        bus.ERR         <= 1'b1;
      end else begin
        unique case (state)
          IDLE: if (bus.REQ_VALID) begin
            base          <= bus.REQ_ADDR & BASE_MASK;
            is_wr         <= bus.REQ_WRITE;
            k             <= '0;
            bus.MEM_VALID <= 1'b1;
            bus.MEM_LOAD  <= !bus.REQ_WRITE;
            bus.MEM_STORE <= bus.REQ_WRITE;
            state         <= HANDSHAKE;
          end
          HANDSHAKE: if (bus.MEM_READY) begin
            bus.MEM_DATA_OUT <= base;
            bus.ACK_ADDR     <= 1'b1;
            state            <= ADDR;
          end
          ADDR: if (addr_acc) begin
            bus.ACK_ADDR    <= 1'b0;
            bus.ACK_DATA_L1 <= 4'h0;
            if (is_wr) begin
              bus.MEM_DATA_OUT <= bus.WB_DATA;
              state            <= STORE_DATA;
            end else begin
              bus.FILL_VALID <= 1'b1;
              bus.FILL_IDX   <= 3'd0;
              bus.FILL_DATA  <= bus.MEM_DATA_IN;
              k              <= 3'd1;
              state          <= LOAD_DATA;
            end
          end
          LOAD_DATA: if (ld_hit) begin
            bus.FILL_VALID  <= 1'b1;
            bus.FILL_IDX    <= k;
            bus.FILL_DATA   <= bus.MEM_DATA_IN;
            bus.ACK_DATA_L1 <= {1'b0, k};
            if (k == LAST) state <= FINISH;
            else           k     <= k + 3'd1;
          end
          STORE_DATA: begin
            if (st_hit) begin
              if (k == LAST) state <= FINISH;
              else           k     <= k + 3'd1;
            end else begin
              bus.MEM_DATA_OUT <= bus.WB_DATA;
              bus.ACK_DATA_L1  <= {1'b0, k};
            end
          end
          FINISH: if (!bus.MEM_READY) begin
            bus.MEM_VALID   <= 1'b0;
            bus.MEM_LOAD    <= 1'b0;
            bus.MEM_STORE   <= 1'b0;
            bus.ACK_ADDR    <= 1'b0;
            bus.ACK_DATA_L1 <= NONE;
            bus.DONE        <= 1'b1;
            k               <= '0;
            state           <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_l1_line_fetch_master.sv
// Bench for l1_line_fetch_master: directed memory/L1 stimulus,
// line-level transfer model and per-cycle output checker.
module tb_l1_line_fetch_master;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  l1_line_fetch_master_if bus();

`ifdef TIMEOUT_EN
  l1_line_fetch_master #(
    .WORDS_PER_LINE(8), .LINE_BYTES_LOG2(5), .TIMEOUT_CYCLES(16)
  ) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
`else
  l1_line_fetch_master #(
    .WORDS_PER_LINE(8), .LINE_BYTES_LOG2(5)
  ) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] wb_base = 32'hB0;
  logic [31:0] dbase = 32'hA0;

  assign bus.WB_DATA = wb_base + {29'd0, bus.WB_IDX};

  // model of the current transfer
  logic [34:0] exp_fill[$];
  int exp_end = 0;
  logic [31:0] cur_base = '0;
  logic cur_wr = 1'b0;
  int done_cnt = 0;
  int err_cnt = 0;
  int fill_cnt = 0;
  bit prev_end = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit cond(input int sel, input logic [3:0] v);
    case (sel)
      0: return bus.REQ_READY;
      1: return bus.MEM_VALID;
      2: return bus.ACK_ADDR;
      3: return !bus.ACK_ADDR;
      4: return bus.ACK_DATA_L1 == v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_neg(input int sel, input logic [3:0] v,
                          input string nm, output bit ok);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (cond(sel, v)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", nm);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.REQ_READY), 32'd1);
    chk({tag, "_mem_valid"}, 32'(bus.MEM_VALID), 32'd0);
    chk({tag, "_mem_load"}, 32'(bus.MEM_LOAD), 32'd0);
    chk({tag, "_mem_store"}, 32'(bus.MEM_STORE), 32'd0);
    chk({tag, "_ack_addr"}, 32'(bus.ACK_ADDR), 32'd0);
    chk({tag, "_ack_l1"}, 32'(bus.ACK_DATA_L1), 32'hF);
    chk({tag, "_fill_valid"}, 32'(bus.FILL_VALID), 32'd0);
    chk({tag, "_done_err"}, 32'({bus.DONE, bus.ERR}), 32'd0);
    chk({tag, "_data_out"}, bus.MEM_DATA_OUT, 32'd0);
    chk({tag, "_wb_idx"}, 32'(bus.WB_IDX), 32'd0);
  endtask

  task automatic request(input logic wr, input logic [31:0] addr,
                         input int nfill, input int outcome);
    bit ok;
    cur_base = addr - (addr % 32'd32);
    cur_wr = wr;
    exp_end = outcome;
    exp_fill.delete();
    for (int i = 0; i < nfill; i++)
      exp_fill.push_back({3'(i), dbase + 32'(i)});
    wait_neg(0, 4'h0, "req_ready", ok);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WRITE = wr;
    bus.REQ_ADDR = addr;
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
  endtask

  task automatic mem_load(input int drop_after, input int rep_idx,
                          input logic [31:0] exp_addr);
    bit ok;
    wait_neg(1, 4'h0, "ld_mem_valid", ok);
    if (!ok) return;
    bus.MEM_READY = 1'b1;
    wait_neg(2, 4'h0, "ld_ack_addr", ok);
    if (!ok) return;
    chk("ld_addr_phase", bus.MEM_DATA_OUT, exp_addr);
    for (int i = 0; i < 8; i++) begin
      bus.ACK_DATA_MEM = 4'(i);
      bus.MEM_DATA_IN = dbase + 32'(i);
      if (i == rep_idx) repeat (4) @(negedge CLK);
      wait_neg(4, 4'(i), "ld_ack_l1", ok);
      if (!ok) return;
      if (i == drop_after) break;
    end
    if (drop_after > 7)
      chk("ld_ack_l1_last", 32'(bus.ACK_DATA_L1), 32'd7);
    bus.MEM_READY = 1'b0;
    bus.ACK_DATA_MEM = 4'hF;
  endtask

  task automatic mem_store(input int rst_at,
                           input logic [31:0] exp_addr);
    bit ok;
    wait_neg(1, 4'h0, "st_mem_valid", ok);
    if (!ok) return;
    bus.MEM_READY = 1'b1;
    wait_neg(2, 4'h0, "st_ack_addr", ok);
    if (!ok) return;
    chk("st_addr_phase", bus.MEM_DATA_OUT, exp_addr);
    bus.ACK_DATA_MEM = 4'hE;
    wait_neg(3, 4'h0, "st_addr_drop", ok);
    if (!ok) return;
    bus.ACK_DATA_MEM = 4'hF;
    for (int i = 0; i < 8; i++) begin
      if (!cond(4, 4'(i))) begin
        wait_neg(4, 4'(i), "st_ack_l1", ok);
        if (!ok) return;
      end
      chk("st_word", bus.MEM_DATA_OUT, 32'hB0 + 32'(i) - 32'hB0 + wb_base);
      if (i == rst_at) begin
        #2 RST_N = 1'b0;
        #1 check_reset("mid_rst");
        exp_end = 0;
        exp_fill.delete();
        bus.MEM_READY = 1'b0;
        bus.ACK_DATA_MEM = 4'hF;
        @(posedge CLK);
        #2 RST_N = 1'b1;
        return;
      end
      repeat (3) begin
        @(negedge CLK);
        chk("st_hold", bus.MEM_DATA_OUT, wb_base + 32'(i));
        chk("st_hold_idx", 32'(bus.ACK_DATA_L1), 32'(i));
      end
      bus.ACK_DATA_MEM = 4'(i);
      @(negedge CLK);
      bus.ACK_DATA_MEM = 4'hF;
    end
    bus.MEM_READY = 1'b0;
  endtask

  // per-cycle comparison against the transfer model
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_end = 0;
        continue;
      end
      if (prev_end) begin
        chk("end_pulse_low", 32'({bus.DONE, bus.ERR}), 32'd0);
        chk("end_req_ready", 32'(bus.REQ_READY), 32'd1);
        chk("end_mem_valid", 32'(bus.MEM_VALID), 32'd0);
      end
      prev_end = bus.DONE || bus.ERR;
      if (bus.FILL_VALID) begin
        fill_cnt++;
        if (exp_fill.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fill_extra actual=idx%0d required=none",
                   bus.FILL_IDX);
        end else begin
          e = exp_fill.pop_front();
          chk("fill_idx", 32'(bus.FILL_IDX), 32'(e[34:32]));
          chk("fill_data", bus.FILL_DATA, e[31:0]);
        end
      end
      if (bus.ACK_ADDR)
        chk("addr_value", bus.MEM_DATA_OUT, cur_base);
      if (bus.MEM_VALID)
        chk("direction", 32'({bus.MEM_LOAD, bus.MEM_STORE}),
            32'({!cur_wr, cur_wr}));
      if (bus.MEM_VALID && bus.MEM_STORE && !bus.ACK_ADDR &&
          bus.ACK_DATA_L1 != 4'hF)
        chk("store_data", bus.MEM_DATA_OUT,
            wb_base + 32'(bus.ACK_DATA_L1));
      if (bus.DONE) begin
        done_cnt++;
        chk("done_expected", 32'(exp_end), 32'd1);
        chk("done_all_fills", 32'(exp_fill.size()), 32'd0);
        chk("done_ack_l1", 32'(bus.ACK_DATA_L1), 32'hF);
        exp_end = 0;
      end
      if (bus.ERR) begin
        err_cnt++;
        chk("err_expected", 32'(exp_end), 32'd2);
        chk("err_fills", 32'(exp_fill.size()), 32'd0);
        exp_end = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0, e0, f0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR = '0;
    bus.MEM_READY = 1'b0;
    bus.MEM_DATA_IN = '0;
    bus.ACK_DATA_MEM = 4'hF;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    @(posedge CLK);
    #2 RST_N = 1'b1;

    // plain load
    d0 = done_cnt; f0 = fill_cnt; dbase = 32'hA0;
    request(1'b0, 32'h0000_0124, 8, 1);
    mem_load(99, 99, 32'h0000_0120);
    repeat (3) @(negedge CLK);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_fills", 32'(fill_cnt - f0), 32'd8);

    // write-back with slow acks
    d0 = done_cnt; wb_base = 32'hB0;
    request(1'b1, 32'h0000_0040, 0, 1);
    mem_store(99, 32'h0000_0040);
    repeat (3) @(negedge CLK);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);

    // stale repeated ack for word 2
    d0 = done_cnt; f0 = fill_cnt; dbase = 32'hC0;
    request(1'b0, 32'h0000_2468, 8, 1);
    mem_load(99, 2, 32'h0000_2460);
    repeat (3) @(negedge CLK);
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_fills", 32'(fill_cnt - f0), 32'd8);

    // memory drops READY after word 3
    d0 = done_cnt; e0 = err_cnt; f0 = fill_cnt; dbase = 32'hD0;
    request(1'b0, 32'h0000_0FFF, 4, 2);
    mem_load(3, 99, 32'h0000_0FE0);
    repeat (3) @(negedge CLK);
    chk("t4_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_fills", 32'(fill_cnt - f0), 32'd4);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // async reset mid-store, then a clean load
    d0 = done_cnt; e0 = err_cnt; wb_base = 32'h5500;
    request(1'b1, 32'h8000_007C, 0, 0);
    mem_store(5, 32'h8000_0060);
    chk("t5_no_end", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    dbase = 32'hE0;
    request(1'b0, 32'h0000_0200, 8, 1);
    mem_load(99, 99, 32'h0000_0200);
    repeat (3) @(negedge CLK);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_no_err", 32'(err_cnt - e0), 32'd0);

    // memory never becomes ready
    e0 = err_cnt;
`ifdef TIMEOUT_EN
    begin
      bit ok;
      int n;
      request(1'b0, 32'h0000_0300, 0, 2);
      wait_neg(1, 4'h0, "t6_mem_valid", ok);
      n = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge CLK);
        n++;
        if (bus.ERR) break;
      end
      chk("t6_tmo_cycles", 32'(n), 32'd16);
      repeat (2) @(negedge CLK);
      chk("t6_err", 32'(err_cnt - e0), 32'd1);
    end
`else
    request(1'b0, 32'h0000_0300, 0, 0);
    repeat (1000) @(negedge CLK);
    chk("t6_still_valid", 32'(bus.MEM_VALID), 32'd1);
    chk("t6_busy", 32'(bus.REQ_READY), 32'd0);
    chk("t6_no_err", 32'(err_cnt - e0), 32'd0);
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b1;
`endif
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
